// File: rtl/loader_pkg.sv
// Shared types and constants for the host-side boot loader that feeds the cpu's
// external instruction/data memory write ports.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } state_e;

  localparam logic [1:0] OP_LOAD_I = 2'b00;
  localparam logic [1:0] OP_LOAD_D = 2'b01;
  localparam logic [1:0] OP_HALT   = 2'b10;
  localparam logic [1:0] OP_GO     = 2'b11;

  // Depths of the instruction and data memories inside the cpu, in 32-bit words.
  localparam int IMEM_DEPTH = 512;
  localparam int DMEM_DEPTH = 1024;
  localparam int CNT_DEF_W  = 16;

endpackage

// File: rtl/cpu_loader.sv
// Boot loader: decodes a host word stream into cpu memory writes and gates the
// cpu enable. Header = {opcode[31:30], count[CNT_W-1:0]}, then base address, then data.
module cpu_loader
  import loader_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_DEPTH,
  parameter int DMEM_WORDS = DMEM_DEPTH,
  parameter int CNT_W      = CNT_DEF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic [31:0]      imem_addr,
  output logic             imem_wen,
  output logic [31:0]      imem_wdata,
  output logic [31:0]      dmem_addr,
  output logic             dmem_wen,
  output logic [31:0]      dmem_wdata,
  output logic             cpu_enable,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  localparam logic [29:0] IMEM_LIM = 30'(IMEM_WORDS);
  localparam logic [29:0] DMEM_LIM = 30'(DMEM_WORDS);

  state_e           state_q, state_d;
  logic             target_q, target_d;    // 0 = imem, 1 = dmem
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      addr_q, addr_d;        // address of the next data beat
  logic [CNT_W-1:0] words_loaded_q, words_loaded_d;
  logic [31:0]      imem_addr_q, imem_addr_d, imem_wdata_q, imem_wdata_d;
  logic [31:0]      dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
  logic             imem_wen_q, imem_wen_d, dmem_wen_q, dmem_wen_d;
  logic             s_ready_q, s_ready_d, busy_q, busy_d;
  logic             cpu_enable_q, cpu_enable_d, error_q, error_d;

  logic       beat;
  logic [1:0] op;
  logic       out_of_range;
  logic       last_beat;

  assign beat         = s_valid && s_ready_q;
  assign op           = s_data[31:30];
  assign out_of_range = target_q ? (addr_q[31:2] >= DMEM_LIM) : (addr_q[31:2] >= IMEM_LIM);
  assign last_beat    = (words_loaded_q == count_q - CNT_W'(1));

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    count_d        = count_q;
    addr_d         = addr_q;
    words_loaded_d = words_loaded_q;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    imem_wen_d     = 1'b0;
    dmem_addr_d    = dmem_addr_q;
    dmem_wdata_d   = dmem_wdata_q;
    dmem_wen_d     = 1'b0;

    case (state_q)
      IDLE: if (beat) begin
        if (op == OP_LOAD_I || op == OP_LOAD_D) begin
          target_d = (op == OP_LOAD_D);
          count_d  = s_data[CNT_W-1:0];
          state_d  = ADDR;
        end else if (op == OP_GO) begin
          state_d = RUN;
        end
      end
      ADDR: if (beat) begin
        if (s_data[1:0] != 2'b00) begin
          state_d = ERR;
        end else if (count_q == '0) begin
          state_d = IDLE;
        end else begin
          addr_d         = s_data;
          words_loaded_d = '0;
          state_d        = DATA;
        end
      end
      DATA: if (beat) begin
        // An out-of-range beat is dropped; writes already made stay in memory.
        if (out_of_range) begin
          state_d = ERR;
        end else begin
          if (target_q) begin
            dmem_addr_d  = addr_q;
            dmem_wdata_d = s_data;
            dmem_wen_d   = 1'b1;
          end else begin
            imem_addr_d  = addr_q;
            imem_wdata_d = s_data;
            imem_wen_d   = 1'b1;
          end
          addr_d = addr_q + 32'd4;
          if (words_loaded_q != '1) words_loaded_d = words_loaded_q + CNT_W'(1);
          if (last_beat) state_d = IDLE;
        end
      end
      RUN: if (beat) begin
        if (op == OP_LOAD_I || op == OP_LOAD_D) state_d = ERR;
        else if (op == OP_HALT) state_d = IDLE;
      end
      default: state_d = ERR;
    endcase

    s_ready_d    = (state_d != ERR);
    busy_d       = (state_d == ADDR) || (state_d == DATA);
    cpu_enable_d = (state_d == RUN);
    error_d      = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      target_q       <= 1'b0;
      count_q        <= '0;
      addr_q         <= '0;
      words_loaded_q <= '0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      imem_wen_q     <= 1'b0;
      dmem_addr_q    <= '0;
      dmem_wdata_q   <= '0;
      dmem_wen_q     <= 1'b0;
      s_ready_q      <= 1'b0;
      busy_q         <= 1'b0;
      cpu_enable_q   <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      count_q        <= count_d;
      addr_q         <= addr_d;
      words_loaded_q <= words_loaded_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      imem_wen_q     <= imem_wen_d;
      dmem_addr_q    <= dmem_addr_d;
      dmem_wdata_q   <= dmem_wdata_d;
      dmem_wen_q     <= dmem_wen_d;
      s_ready_q      <= s_ready_d;
      busy_q         <= busy_d;
      cpu_enable_q   <= cpu_enable_d;
      error_q        <= error_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wen     = imem_wen_q;
  assign imem_wdata   = imem_wdata_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wen     = dmem_wen_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign cpu_enable   = cpu_enable_q;
  assign busy         = busy_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_cpu_loader.sv
// Scoreboarded bench for cpu_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares every write strobe the DUT produces.
module tb_cpu_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
  logic        imem_wen, dmem_wen, cpu_enable, busy, error;
  logic [15:0] words_loaded;

  cpu_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
    .cpu_enable(cpu_enable), .busy(busy), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%08h", name, act);
    end
  endfunction

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (imem_wen || dmem_wen) begin
      wr_t e;
      if (imem_wen && dmem_wen) chk("both_wen", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {31'd0, dmem_wen}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_mem_is_d", {31'd0, dmem_wen}, {31'd0, e.is_d});
        chk("wr_addr", dmem_wen ? dmem_addr : imem_addr, e.addr);
        chk("wr_data", dmem_wen ? dmem_wdata : imem_wdata, e.data);
      end
    end
  end

  task automatic push(input logic is_d, input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.is_d = is_d; w.addr = a; w.data = d;
    exp_q.push_back(w);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic beat(input logic [31:0] w);
    int n = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("s_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle();
    s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_outputs", {imem_wen, dmem_wen, cpu_enable, busy, error}, 32'd0);
    chk("rst_words", {16'd0, words_loaded}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", {31'd0, s_ready}, 32'd1);

    // LOAD_I N=3 at 0x0, back-to-back data
    beat(32'h0000_0003);
    chk("t1_busy_hdr", {31'd0, busy}, 32'd1);
    beat(32'h0000_0000);
    for (int i = 1; i <= 3; i++) begin
      push(1'b0, 32'(4 * (i - 1)), 32'hAAAA_0000 + 32'(i));
      beat(32'hAAAA_0000 + 32'(i));
    end
    chk("t1_words", {16'd0, words_loaded}, 32'd3);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    idle();

    // LOAD_D N=2 at 0x10, valid 1-0-1
    beat(32'h4000_0002);
    beat(32'h0000_0010);
    push(1'b1, 32'h10, 32'hD000_0001);
    beat(32'hD000_0001);
    chk("t2_wen_first", {31'd0, dmem_wen}, 32'd1);
    idle();
    chk("t2_wen_gap", {31'd0, dmem_wen}, 32'd0);
    chk("t2_addr_hold", dmem_addr, 32'h10);
    push(1'b1, 32'h14, 32'hD000_0002);
    beat(32'hD000_0002);
    chk("t2_words", {16'd0, words_loaded}, 32'd2);
    idle();

    // GO, GO ignored, HALT, then LOAD_I N=0
    chk("t3_en_before", {31'd0, cpu_enable}, 32'd0);
    beat(32'hC000_0000);
    chk("t3_en_go", {31'd0, cpu_enable}, 32'd1);
    beat(32'hC000_0000);
    chk("t3_en_go2", {31'd0, cpu_enable}, 32'd1);
    beat(32'h8000_0000);
    chk("t3_en_halt", {31'd0, cpu_enable}, 32'd0);
    beat(32'h0000_0000);
    beat(32'h0000_0100);
    chk("t3_n0_busy", {31'd0, busy}, 32'd0);
    chk("t3_n0_err", {31'd0, error}, 32'd0);
    idle();

    // Misaligned base address
    beat(32'h0000_0001);
    beat(32'h0000_0002);
    chk("t4a_error", {31'd0, error}, 32'd1);
    chk("t4a_s_ready", {31'd0, s_ready}, 32'd0);
    do_reset();

    // Range check: 0x7FC is the last imem word, 0x800 is out of range
    beat(32'h0000_0002);
    beat(32'h0000_07FC);
    push(1'b0, 32'h7FC, 32'h1111_0001);
    beat(32'h1111_0001);
    beat(32'h1111_0002);
    chk("t4b_error", {31'd0, error}, 32'd1);
    chk("t4b_words", {16'd0, words_loaded}, 32'd1);
    idle();
    chk("t4b_no_wen", {30'd0, imem_wen, dmem_wen}, 32'd0);
    do_reset();

    // LOAD_I while running
    beat(32'hC000_0000);
    chk("t4c_en", {31'd0, cpu_enable}, 32'd1);
    beat(32'h0000_0001);
    chk("t4c_error", {31'd0, error}, 32'd1);
    chk("t4c_en_drop", {31'd0, cpu_enable}, 32'd0);
    do_reset();

    // Reset during DATA after 1 of 4 words
    beat(32'h0000_0004);
    beat(32'h0000_0020);
    push(1'b0, 32'h20, 32'hBEEF_0000);
    beat(32'hBEEF_0000);
    s_valid = 1'b1;
    s_data  = 32'hBEEF_0001;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_outputs", {s_ready, imem_wen, dmem_wen, cpu_enable, busy, error}, 32'd0);
    chk("t5_rst_words", {16'd0, words_loaded}, 32'd0);
    chk("t5_rst_addr", imem_addr, 32'd0);
    rst = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    beat(32'h0000_0002);
    beat(32'h0000_0040);
    push(1'b0, 32'h40, 32'hCAFE_0001);
    beat(32'hCAFE_0001);
    push(1'b0, 32'h44, 32'hCAFE_0002);
    beat(32'hCAFE_0002);
    chk("t5_words", {16'd0, words_loaded}, 32'd2);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
